// File: rtl/ram_arb_pkg.sv
// Types, defaults and helpers shared by the RAM arbiter and its bus.
package ram_arb_pkg;

`include "definitions.svh"

    localparam int unsigned BYTE  = `BYTE;
    localparam int unsigned NBITS = `NBITS;

    localparam int unsigned NREQ_DEF      = 2;
    localparam int unsigned MAX_BURST_DEF = 4;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Next requester index with wrap-around at n.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/ram_bus.sv
// Single-port RAM connection: one address/data/we per cycle, registered read data.
interface ram_bus;
    import ram_arb_pkg::*;

    logic [NBITS-1:0] addr;
    logic [BYTE-1:0]  data;
    logic             we;
    logic [BYTE-1:0]  q;

    modport master (
        output addr,
        output data,
        output we,
        input  q
    );

    modport slave (
        input  addr,
        input  data,
        input  we,
        output q
    );

endinterface

// File: rtl/definitions.svh
// Shared bus widths for the RAM subsystem.
`ifndef DEFINITIONS_SVH
`define DEFINITIONS_SVH
`define BYTE 8
`define NBITS 8
`endif

// File: rtl/rr_picker.sv
// Round-robin pick: rotate requests so rr_ptr lands at bit 0, take the lowest set bit,
// then rotate the winner index back.
module rr_picker #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned PW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   rr_ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic              hit;
    int unsigned       pos;
    int unsigned       sum;

    assign dbl = {req, req};

    always_comb begin
        rot = '0;
        hit = 1'b0;
        pos = 0;
        for (int i = 0; i < int'(NREQ); i++) begin
            rot[i] = dbl[32'(rr_ptr) + i];
        end
        // Descending scan leaves the lowest set position in pos.
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                hit = 1'b1;
                pos = i;
            end
        end
        sum = 32'(rr_ptr) + pos;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        idx = PW'(sum);
        gnt = '0;
        if (hit) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between NREQ requesters,
// with capped locked bursts and requester-tagged read data.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned NREQ      = NREQ_DEF,
    parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       lock,
    input  logic [NREQ-1:0]       we,
    input  logic [NREQ*NBITS-1:0] addr,
    input  logic [NREQ*BYTE-1:0]  wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       rvalid,
    output logic [BYTE-1:0]       rdata,
    ram_bus.master                bus
);

    localparam int unsigned PW = $clog2(NREQ);
    localparam int unsigned BW = $clog2(MAX_BURST + 1);

    localparam logic [BW-1:0] BURST_ONE  = BW'(1);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    arb_state_t      state_q;
    arb_state_t      state_d;
    logic [PW-1:0]   rr_ptr_q;
    logic [PW-1:0]   rr_ptr_d;
    logic [PW-1:0]   owner_q;
    logic [PW-1:0]   owner_d;
    logic [BW-1:0]   burst_q;
    logic [BW-1:0]   burst_d;
    logic [NREQ-1:0] rvalid_q;

    logic [NREQ-1:0] pick_gnt;
    logic [PW-1:0]   pick_idx;
    logic [PW-1:0]   g;
    logic [PW-1:0]   sel;
    logic            granted;

    rr_picker #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .gnt    (pick_gnt),
        .idx    (pick_idx)
    );

    always_comb begin
        gnt = '0;
        g   = '0;
        if (rst_n) begin
            if (state_q == ARB) begin
                gnt = pick_gnt;
                g   = pick_idx;
            end else begin
                g = owner_q;
                if (req[owner_q]) begin
                    gnt[owner_q] = 1'b1;
                end
            end
        end
    end

    assign granted = |gnt;
    assign sel     = granted ? g : '0;

    assign bus.addr = addr[32'(sel) * NBITS +: NBITS];
    assign bus.data = wdata[32'(sel) * BYTE +: BYTE];
    assign bus.we   = we[sel] & granted;

    assign rdata  = bus.q;
    // A read result due during reset is dropped.
    assign rvalid = rvalid_q & {NREQ{rst_n}};

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        burst_d  = burst_q;
        case (state_q)
            ARB: begin
                if (granted) begin
                    if (lock[g] && (MAX_BURST > 1)) begin
                        state_d = LOCKED;
                        owner_d = g;
                        burst_d = BURST_ONE;
                    end else begin
                        rr_ptr_d = PW'(wrap_inc(32'(g), NREQ));
                    end
                end
            end
            LOCKED: begin
                // The grant that reaches the cap is still served, then priority moves on.
                if (granted && lock[owner_q] && (burst_q < BURST_LAST)) begin
                    burst_d = burst_q + BURST_ONE;
                end else begin
                    state_d  = ARB;
                    rr_ptr_d = PW'(wrap_inc(32'(owner_q), NREQ));
                    burst_d  = '0;
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ARB;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            burst_q  <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            burst_q  <= burst_d;
            rvalid_q <= gnt & ~we;
        end
    end

endmodule
